// File: rtl/param_regfile_sb.sv
// Parameterised 2R/2W register file with a per-register pending-write
// scoreboard, same-cycle write bypass and a registered busy population count.
module param_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  busy_1,
  output logic                  busy_2,
  input  logic                  wr_en_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [DATA_WIDTH-1:0] wr_data_a,
  input  logic [DATA_WIDTH-1:0] wr_data_b,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [ADDR_WIDTH:0]   busy_count
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  wa_ok;
  logic                  wb_ok;
  logic                  rsv_ok;

  // Address 0 is inert for writes and reserves when hardwired to zero
  assign wa_ok  = wr_en_a && !(ZERO_REG && wr_addr_a == '0);
  assign wb_ok  = wr_en_b && !(ZERO_REG && wr_addr_b == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

  // Port B checked first so it wins the bypass on a double write
  always_comb begin
    read_data_1 = regs[read_register_1];
    if (ZERO_REG && read_register_1 == '0)
      read_data_1 = '0;
    else if (wb_ok && wr_addr_b == read_register_1)
      read_data_1 = wr_data_b;
    else if (wa_ok && wr_addr_a == read_register_1)
      read_data_1 = wr_data_a;
  end

  always_comb begin
    read_data_2 = regs[read_register_2];
    if (ZERO_REG && read_register_2 == '0)
      read_data_2 = '0;
    else if (wb_ok && wr_addr_b == read_register_2)
      read_data_2 = wr_data_b;
    else if (wa_ok && wr_addr_a == read_register_2)
      read_data_2 = wr_data_a;
  end

  assign busy_1 = busy[read_register_1];
  assign busy_2 = busy[read_register_2];

  // Reserve applied after the write clears: it belongs to the newer producer
  always_comb begin
    busy_nxt = busy;
    if (wa_ok)
      busy_nxt[wr_addr_a] = 1'b0;
    if (wb_ok)
      busy_nxt[wr_addr_b] = 1'b0;
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wa_ok)
        regs[wr_addr_a] <= wr_data_a;
      if (wb_ok)
        regs[wr_addr_b] <= wr_data_b;
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_param_regfile_sb.sv
// Scoreboard bench: a default 32x32 instance and a 64-bit, 8-entry
// instance with register 0 writable, checked against an array model.
module tb_param_regfile_sb;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        m_rst, m_wea, m_web, m_rsv, m_b1, m_b2;
  logic [4:0]  m_rr1, m_rr2, m_aa, m_ab, m_ra;
  logic [31:0] m_rd1, m_rd2, m_da, m_db;
  logic [5:0]  m_cnt;

  logic        w_rst, w_wea, w_web, w_rsv, w_b1, w_b2;
  logic [2:0]  w_rr1, w_rr2, w_aa, w_ab, w_ra;
  logic [63:0] w_rd1, w_rd2, w_da, w_db;
  logic [3:0]  w_cnt;

  param_regfile_sb dut (
    .clock(clock), .Reset(m_rst),
    .read_register_1(m_rr1), .read_register_2(m_rr2),
    .read_data_1(m_rd1), .read_data_2(m_rd2),
    .busy_1(m_b1), .busy_2(m_b2),
    .wr_en_a(m_wea), .wr_en_b(m_web),
    .wr_addr_a(m_aa), .wr_addr_b(m_ab),
    .wr_data_a(m_da), .wr_data_b(m_db),
    .rsv_en(m_rsv), .rsv_addr(m_ra),
    .busy_count(m_cnt)
  );

  param_regfile_sb #(
    .DATA_WIDTH(64), .NUM_REGS(8), .ZERO_REG(1'b0)
  ) dut_w (
    .clock(clock), .Reset(w_rst),
    .read_register_1(w_rr1), .read_register_2(w_rr2),
    .read_data_1(w_rd1), .read_data_2(w_rd2),
    .busy_1(w_b1), .busy_2(w_b2),
    .wr_en_a(w_wea), .wr_en_b(w_web),
    .wr_addr_a(w_aa), .wr_addr_b(w_ab),
    .wr_data_a(w_da), .wr_data_b(w_db),
    .rsv_en(w_rsv), .rsv_addr(w_ra),
    .busy_count(w_cnt)
  );

  typedef struct {
    bit          sel;
    bit          rst;
    logic [63:0] rd1;
    logic [63:0] rd2;
    bit          b1;
    bit          b2;
    int          cnt;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [63:0] regs [2][32];
  bit          busy [2][32];
  int          checks = 0;
  int          errors = 0;

  function automatic int nregs(bit s);
    return s ? 8 : 32;
  endfunction

  function automatic bit zr(bit s);
    return s ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [63:0] mread(bit s, int a, bit wea, int aa,
      logic [63:0] da, bit web, int ab, logic [63:0] db);
    if (zr(s) && a == 0) return 64'd0;
    if (web && ab == a) return db;
    if (wea && aa == a) return da;
    return regs[s][a];
  endfunction

  task automatic cyc(bit s, bit rst, bit wea, int aa, logic [63:0] da,
      bit web, int ab, logic [63:0] db, bit rsv, int ra,
      int r1, int r2, string nm);
    exp_t e;
    int c;
    @(posedge clock);
    #1;
    if (!s) begin
      da[63:32] = '0;
      db[63:32] = '0;
    end
    m_rst = !s && rst; m_wea = !s && wea; m_web = !s && web;
    m_rsv = !s && rsv;
    m_aa = 5'(aa); m_ab = 5'(ab); m_ra = 5'(ra);
    m_da = da[31:0]; m_db = db[31:0];
    m_rr1 = 5'(r1); m_rr2 = 5'(r2);
    w_rst = s && rst; w_wea = s && wea; w_web = s && web;
    w_rsv = s && rsv;
    w_aa = 3'(aa); w_ab = 3'(ab); w_ra = 3'(ra);
    w_da = da; w_db = db;
    w_rr1 = 3'(r1); w_rr2 = 3'(r2);
    e.sel = s; e.rst = rst; e.name = nm;
    e.rd1 = mread(s, r1, wea, aa, da, web, ab, db);
    e.rd2 = mread(s, r2, wea, aa, da, web, ab, db);
    e.b1 = busy[s][r1];
    e.b2 = busy[s][r2];
    c = 0;
    for (int i = 0; i < nregs(s); i++) c += int'(busy[s][i]);
    e.cnt = c;
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[s][i] = 64'd0;
        busy[s][i] = 1'b0;
      end
    end else begin
      if (wea && !(zr(s) && aa == 0)) begin
        regs[s][aa] = da; busy[s][aa] = 1'b0;
      end
      if (web && !(zr(s) && ab == 0)) begin
        regs[s][ab] = db; busy[s][ab] = 1'b0;
      end
      if (rsv && !(zr(s) && ra == 0)) busy[s][ra] = 1'b1;
    end
  endtask

  task automatic idle(bit s, int r1, int r2, string nm);
    cyc(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, nm);
  endtask

  task automatic wr(bit s, int a, logic [63:0] d, int r1, string nm);
    cyc(s, 0, 1, a, d, 0, 0, 0, 0, 0, r1, r1, nm);
  endtask

  task automatic rsvc(bit s, int a, string nm);
    cyc(s, 0, 0, 0, 0, 0, 0, 0, 1, a, a, 0, nm);
  endtask

  task automatic chk(string nm, string f, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, f, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.rst) begin
          if (e.sel) begin
            chk(e.name, "rd1", w_rd1, e.rd1);
            chk(e.name, "rd2", w_rd2, e.rd2);
            chk(e.name, "busy1", 64'(w_b1), 64'(e.b1));
            chk(e.name, "busy2", 64'(w_b2), 64'(e.b2));
            chk(e.name, "count", 64'(w_cnt), 64'(e.cnt));
          end else begin
            chk(e.name, "rd1", 64'(m_rd1), e.rd1);
            chk(e.name, "rd2", 64'(m_rd2), e.rd2);
            chk(e.name, "busy1", 64'(m_b1), 64'(e.b1));
            chk(e.name, "busy2", 64'(m_b2), 64'(e.b2));
            chk(e.name, "count", 64'(m_cnt), 64'(e.cnt));
          end
        end
      end
    end
  end

  initial begin
    bit s;
    int n;
    m_rst = 0; m_wea = 0; m_web = 0; m_rsv = 0;
    m_aa = 0; m_ab = 0; m_ra = 0; m_da = 0; m_db = 0;
    m_rr1 = 0; m_rr2 = 0;
    w_rst = 0; w_wea = 0; w_web = 0; w_rsv = 0;
    w_aa = 0; w_ab = 0; w_ra = 0; w_da = 0; w_db = 0;
    w_rr1 = 0; w_rr2 = 0;

    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_m");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_w");
    idle(0, 1, 31, "post_rst_m");
    idle(1, 1, 7, "post_rst_w");

    wr(0, 1, 64'hABCDEF12, 1, "s1_wr");
    idle(0, 1, 0, "s1_rd");

    wr(0, 5, 64'h11111111, 5, "s2_byp");
    cyc(0, 0, 1, 5, 64'hAAAA0000, 1, 5, 64'hBBBB0000, 0, 0, 5, 5, "s2_both");
    idle(0, 5, 1, "s2_later");

    wr(0, 0, 64'hDEADBEEF, 0, "s3_z_wr");
    rsvc(0, 0, "s3_z_rsv");
    idle(0, 0, 0, "s3_z_rd");
    wr(1, 0, 64'hDEADBEEF, 0, "s3_nz_wr");
    idle(1, 0, 1, "s3_nz_rd");

    rsvc(0, 3, "s4_rsv3");
    rsvc(0, 7, "s4_rsv7");
    rsvc(0, 7, "s4_rsv7_again");
    idle(0, 3, 7, "s4_cnt2");
    wr(0, 3, 64'h33, 3, "s4_wr3");
    idle(0, 3, 7, "s4_cnt1");
    cyc(0, 0, 1, 7, 64'h77, 0, 0, 0, 1, 7, 7, 3, "s4_rsv_wr7");
    idle(0, 7, 3, "s4_after");

    for (int i = 0; i < 32; i++) rsvc(0, i, "s5_rsv_m");
    idle(0, 0, 31, "s5_full_m");
    cyc(0, 1, 1, 9, 64'h99, 0, 0, 0, 1, 9, 9, 1, "s5_rst_m");
    idle(0, 9, 1, "s5_after_m");
    for (int i = 0; i < 8; i++) rsvc(1, i, "s5_rsv_w");
    idle(1, 0, 7, "s5_full_w");
    cyc(1, 1, 1, 2, 64'h22, 0, 0, 0, 1, 2, 2, 0, "s5_rst_w");
    idle(1, 2, 0, "s5_after_w");

    wr(1, 7, 64'hFFFFFFFF00000001, 7, "s6_wr");
    idle(1, 7, 0, "s6_rd");

    for (int k = 0; k < 400; k++) begin
      s = ($urandom_range(0, 3) == 0);
      n = nregs(s) - 1;
      begin
        int aa, ab, r1, r2;
        aa = $urandom_range(0, n);
        ab = ($urandom_range(0, 3) == 0) ? aa : $urandom_range(0, n);
        r1 = ($urandom_range(0, 2) == 0) ? aa : $urandom_range(0, n);
        r2 = ($urandom_range(0, 2) == 0) ? ab : $urandom_range(0, n);
        cyc(s, $urandom_range(0, 79) == 0,
            1'($urandom_range(0, 1)), aa, {$urandom, $urandom},
            1'($urandom_range(0, 1)), ab, {$urandom, $urandom},
            1'($urandom_range(0, 1)), $urandom_range(0, n),
            r1, r2, "rand");
      end
    end

    repeat (3) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_regfile_sb.md
PARAM_REGFILE_SB -- requirements
Module: param_regfile_sb

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning register count; legal values are powers of two, 2 to 256.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(NUM_REGS), meaning register address width.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.

Ports (name direction width meaning):
REQ-005 clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 read_register_1, read_register_2  input  ADDR_WIDTH  read port addresses.
REQ-008 read_data_1, read_data_2  output  DATA_WIDTH  combinational read data.
REQ-009 busy_1, busy_2  output  1  pending-write (scoreboard) bit of the addressed register.
REQ-010 wr_en_a, wr_en_b  input  1  write enables, ports A and B.
REQ-011 wr_addr_a, wr_addr_b  input  ADDR_WIDTH  write addresses.
REQ-012 wr_data_a, wr_data_b  input  DATA_WIDTH  write data.
REQ-013 rsv_en  input  1  reserve request: marks a register as awaiting write-back.
REQ-014 rsv_addr  input  ADDR_WIDTH  register to reserve.
REQ-015 busy_count  output  ADDR_WIDTH+1  number of registers currently busy.

Function
REQ-016 Writes SHALL commit on the rising clock edge when enabled; the written value is visible on read ports from the next cycle.
REQ-017 Read ports SHALL bypass: a read address matching an enabled write address in the same cycle returns that cycle's write data.
REQ-018 When both write ports target the same address in one cycle, port B SHALL win for both storage and bypass.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 return 0, and busy for address 0 is always 0.
REQ-020 With ZERO_REG=0, register 0 SHALL behave like any other register.
REQ-021 rsv_en SHALL set the busy bit of rsv_addr on the next edge, unless rsv_addr is 0 and ZERO_REG=1.
REQ-022 An enabled write to a register SHALL clear its busy bit on the same edge.
REQ-023 If reserve and write target the same register in the same cycle, the busy bit SHALL end set, because the reserve belongs to the newer producer; the data write still commits.
REQ-024 Reserving an already-busy register SHALL leave it busy and SHALL NOT change busy_count.
REQ-025 busy_1 and busy_2 SHALL reflect the registered busy bits, without bypass of same-cycle reserve or write.
REQ-026 busy_count SHALL equal the population count of the busy bits, registered and updated on the same edge as those bits; its range is 0 to NUM_REGS.
REQ-027 Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Reset
REQ-028 While Reset is high at a rising edge, all registers SHALL clear to 0, all busy bits SHALL clear, and busy_count SHALL become 0.
REQ-029 During a reset cycle, writes and reserves SHALL be ignored, including any reserve or write issued in that cycle.
REQ-030 After reset, all reads SHALL return 0 until written, and busy_1, busy_2 and busy_count SHALL all be 0.

Verification
REQ-031 Scenario 1: Reset, then write 0xABCDEF12 to register 1 via port A; read register 1 the next cycle -> 0xABCDEF12. Read register 0 -> 0x00000000.
REQ-032 Scenario 2: Write 0x11111111 to register 5 and read register 5 in the same cycle -> read_data returns 0x11111111 combinationally (bypass). Repeat with both ports writing 0xAAAA0000 (A) and 0xBBBB0000 (B) to register 5 -> bypass shows 0xBBBB0000, and a later read shows 0xBBBB0000.
REQ-033 Scenario 3: Write 0xDEADBEEF to register 0 with ZERO_REG=1 -> read returns 0, busy 0. With ZERO_REG=0 -> read returns 0xDEADBEEF.
REQ-034 Scenario 4: Reserve registers 3 and 7 -> busy_count=2, busy_1=1 for address 3. Write register 3 -> busy_count=1. Reserve and write register 7 in the same cycle -> register 7 stays busy, data updated, busy_count=1.
REQ-035 Scenario 5: Reserve all registers with ZERO_REG=0 -> busy_count=NUM_REGS (32). Assert Reset while also writing and reserving -> all data 0, busy_count=0, and the write is not committed.
REQ-036 Scenario 6: Parameter sweep with DATA_WIDTH=64, NUM_REGS=8 -> write 0xFFFFFFFF00000001 to register 7 and read it back exactly; busy_count width is 4 bits.
